tlb_op_ctrl: RTL and testbench

- Sequencer for the privileged TLB-maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Sits between the execute stage / CSR file and the TLB array. Drives the array's write port, read port and invtlb port. Borrows data search port 1 while busy.
- Returns results to the CSR file as a single update pulse, and signals completion back to the pipeline.

---
 rtl/tlb_pkg.sv | 31 +++
 rtl/tlb_op_ctrl_if.sv | 23 ++
 rtl/tlb_elo_pack.sv | 43 ++++
 rtl/tlb_op_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared constants for the TLB maintenance sequencer: op codes, FSM states and
// the packed TLBELO bit layout.
package tlb_pkg;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SRCH = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_INV  = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   localparam int ELO_V   = 0;
   localparam int ELO_D   = 1;
   localparam int ELO_PLV = 2;
   localparam int ELO_MAT = 4;
   localparam int ELO_G   = 6;
   localparam int ELO_PPN = 8;

   localparam logic [5:0] PS_4K      = 6'h0c;
   localparam logic [5:0] PS_4M      = 6'h16;
   localparam logic [4:0] INV_OP_MAX = 5'd6;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Request/completion channel between the execute stage and the TLB op sequencer.
interface tlb_op_ctrl_if;
   // A request transfers on a cycle where op_valid && op_ready; the master holds
   // op_valid and its payload stable until then. op_done/op_ine are one-cycle pulses.
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [4:0]  inv_op;
   logic [9:0]  inv_asid;
   logic [31:0] inv_va;
   logic        op_done;
   logic        op_ine;

   modport master (
      output op_valid, op_code, inv_op, inv_asid, inv_va,
      input  op_ready, op_done, op_ine
   );

   modport slave (
      input  op_valid, op_code, inv_op, inv_asid, inv_va,
      output op_ready, op_done, op_ine
   );
endinterface

// File: rtl/tlb_elo_pack.sv
// Pure combinational conversion between the 32-bit TLBELO layout and split entry fields:
// elo_i is unpacked onto the *_o fields, the *_i fields are packed onto elo_o.
module tlb_elo_pack
   import tlb_pkg::*;
(
   input  logic [31:0] elo_i,
   output logic        v_o,
   output logic        d_o,
   output logic [1:0]  plv_o,
   output logic [1:0]  mat_o,
   output logic        g_o,
   output logic [19:0] ppn_o,
   input  logic        v_i,
   input  logic        d_i,
   input  logic [1:0]  plv_i,
   input  logic [1:0]  mat_i,
   input  logic        g_i,
   input  logic [19:0] ppn_i,
   output logic [31:0] elo_o
);

   assign v_o   = elo_i[ELO_V];
   assign d_o   = elo_i[ELO_D];
   assign plv_o = elo_i[ELO_PLV +: 2];
   assign mat_o = elo_i[ELO_MAT +: 2];
   assign g_o   = elo_i[ELO_G];
   assign ppn_o = elo_i[ELO_PPN +: 20];

   // Bit 7 and [31:28] are reserved and always read back as zero.
   always_comb begin
      elo_o                 = '0;
      elo_o[ELO_V]          = v_i;
      elo_o[ELO_D]          = d_i;
      elo_o[ELO_PLV +: 2]   = plv_i;
      elo_o[ELO_MAT +: 2]   = mat_i;
      elo_o[ELO_G]          = g_i;
      elo_o[ELO_PPN +: 20]  = ppn_i;
   end

   logic unused_bits;
   assign unused_bits = ^{elo_i[31:28], elo_i[7]};

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: drives the TLB array ports,
// borrows search port 1 and returns results to the CSR file as one update pulse.
module tlb_op_ctrl
   import tlb_pkg::*;
#(
   parameter int TLBNUM = 16,
   parameter int IDXW   = $clog2(TLBNUM)
) (
   input  logic             clk,
   input  logic             reset,
   tlb_op_ctrl_if.slave     req,
   input  logic [9:0]       csr_asid,
   input  logic [18:0]      csr_ehi_vppn,
   input  logic [IDXW-1:0]  csr_idx,
   input  logic [5:0]       csr_ps,
   input  logic             csr_ne,
   input  logic [31:0]      csr_elo0,
   input  logic [31:0]      csr_elo1,
   input  logic             csr_ecode_tlbr,
   output logic             s1_sel,
   output logic [18:0]      s1_vppn,
   output logic             s1_va_bit12,
   output logic [9:0]       s1_asid,
   input  logic             s1_found,
   input  logic [IDXW-1:0]  s1_index,
   output logic             we,
   output logic [IDXW-1:0]  w_index,
   output logic             w_e,
   output logic [18:0]      w_vppn,
   output logic [5:0]       w_ps,
   output logic [9:0]       w_asid,
   output logic             w_g,
   output logic [19:0]      w_ppn0,
   output logic [19:0]      w_ppn1,
   output logic [1:0]       w_plv0,
   output logic [1:0]       w_plv1,
   output logic [1:0]       w_mat0,
   output logic [1:0]       w_mat1,
   output logic             w_d0,
   output logic             w_d1,
   output logic             w_v0,
   output logic             w_v1,
   output logic [IDXW-1:0]  r_index,
   input  logic             r_e,
   input  logic [18:0]      r_vppn,
   input  logic [5:0]       r_ps,
   input  logic [9:0]       r_asid,
   input  logic             r_g,
   input  logic [19:0]      r_ppn0,
   input  logic [19:0]      r_ppn1,
   input  logic [1:0]       r_plv0,
   input  logic [1:0]       r_plv1,
   input  logic [1:0]       r_mat0,
   input  logic [1:0]       r_mat1,
   input  logic             r_d0,
   input  logic             r_d1,
   input  logic             r_v0,
   input  logic             r_v1,
   output logic             invtlb_valid,
   output logic [4:0]       invtlb_op,
   output logic             upd_valid,
   output logic             upd_kind,
   output logic             upd_ne,
   output logic [IDXW-1:0]  upd_idx,
   output logic [5:0]       upd_ps,
   output logic [18:0]      upd_vppn,
   output logic [9:0]       upd_asid,
   output logic [31:0]      upd_elo0,
   output logic [31:0]      upd_elo1,
   output state_e           dbg_state
);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [4:0]       inv_op_q, inv_op_d;
   logic [9:0]       inv_asid_q, inv_asid_d;
   logic [31:12]     inv_va_q, inv_va_d;
   logic [IDXW-1:0]  fill_cnt_q, fill_cnt_d;
   logic [IDXW-1:0]  fill_q, fill_d;
   logic             upd_ne_q, upd_ne_d;
   logic [IDXW-1:0]  upd_idx_q, upd_idx_d;
   logic [5:0]       upd_ps_q, upd_ps_d;
   logic [18:0]      upd_vppn_q, upd_vppn_d;
   logic [9:0]       upd_asid_q, upd_asid_d;
   logic [31:0]      upd_elo0_q, upd_elo0_d;
   logic [31:0]      upd_elo1_q, upd_elo1_d;

   logic             g0, g1, inv_ok;
   logic [31:0]      rd_elo0, rd_elo1;

   // Each instance unpacks a CSR ELO for the write port and repacks the read entry.
   tlb_elo_pack u_elo0 (
      .elo_i(csr_elo0), .v_o(w_v0), .d_o(w_d0), .plv_o(w_plv0), .mat_o(w_mat0),
      .g_o(g0), .ppn_o(w_ppn0),
      .v_i(r_v0), .d_i(r_d0), .plv_i(r_plv0), .mat_i(r_mat0), .g_i(r_g),
      .ppn_i(r_ppn0), .elo_o(rd_elo0)
   );

   tlb_elo_pack u_elo1 (
      .elo_i(csr_elo1), .v_o(w_v1), .d_o(w_d1), .plv_o(w_plv1), .mat_o(w_mat1),
      .g_o(g1), .ppn_o(w_ppn1),
      .v_i(r_v1), .d_i(r_d1), .plv_i(r_plv1), .mat_i(r_mat1), .g_i(r_g),
      .ppn_i(r_ppn1), .elo_o(rd_elo1)
   );

   assign inv_ok = (inv_op_q <= INV_OP_MAX);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      inv_op_d   = inv_op_q;
      inv_asid_d = inv_asid_q;
      inv_va_d   = inv_va_q;
      fill_d     = fill_q;
      fill_cnt_d = (fill_cnt_q == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt_q + 1'b1;
      upd_ne_d   = upd_ne_q;
      upd_idx_d  = upd_idx_q;
      upd_ps_d   = upd_ps_q;
      upd_vppn_d = upd_vppn_q;
      upd_asid_d = upd_asid_q;
      upd_elo0_d = upd_elo0_q;
      upd_elo1_d = upd_elo1_q;
      case (state_q)
         ST_IDLE: begin
            if (req.op_valid) begin
               op_d       = req.op_code;
               inv_op_d   = req.inv_op;
               inv_asid_d = req.inv_asid;
               inv_va_d   = req.inv_va[31:12];
               fill_d     = fill_cnt_q;
               case (req.op_code)
                  OP_SRCH:        state_d = ST_SRCH;
                  OP_RD:          state_d = ST_RD;
                  OP_WR, OP_FILL: state_d = ST_WR;
                  OP_INV:         state_d = ST_INV;
                  default:        state_d = ST_DONE;
               endcase
            end
         end
         ST_SRCH: begin
            upd_ne_d  = ~s1_found;
            upd_idx_d = s1_found ? s1_index : csr_idx;
            state_d   = ST_DONE;
         end
         ST_RD: begin
            // An invalid entry reads back as all-zero with NE set.
            upd_ne_d   = ~r_e;
            upd_ps_d   = r_e ? r_ps   : '0;
            upd_vppn_d = r_e ? r_vppn : '0;
            upd_asid_d = r_e ? r_asid : '0;
            upd_elo0_d = r_e ? rd_elo0 : '0;
            upd_elo1_d = r_e ? rd_elo1 : '0;
            state_d    = ST_DONE;
         end
         ST_WR, ST_INV: state_d = ST_DONE;
         ST_DONE:       state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         inv_op_q   <= '0;
         inv_asid_q <= '0;
         inv_va_q   <= '0;
         fill_cnt_q <= '0;
         fill_q     <= '0;
         upd_ne_q   <= 1'b0;
         upd_idx_q  <= '0;
         upd_ps_q   <= '0;
         upd_vppn_q <= '0;
         upd_asid_q <= '0;
         upd_elo0_q <= '0;
         upd_elo1_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         inv_op_q   <= inv_op_d;
         inv_asid_q <= inv_asid_d;
         inv_va_q   <= inv_va_d;
         fill_cnt_q <= fill_cnt_d;
         fill_q     <= fill_d;
         upd_ne_q   <= upd_ne_d;
         upd_idx_q  <= upd_idx_d;
         upd_ps_q   <= upd_ps_d;
         upd_vppn_q <= upd_vppn_d;
         upd_asid_q <= upd_asid_d;
         upd_elo0_q <= upd_elo0_d;
         upd_elo1_q <= upd_elo1_d;
      end
   end

   assign req.op_ready = (state_q == ST_IDLE);
   assign req.op_done  = (state_q == ST_DONE);
   assign req.op_ine   = (state_q == ST_DONE) && (op_q == OP_INV) && !inv_ok;

   // Search port 1 carries the EHI lookup in SRCH and the invalidate key in INV.
   assign s1_sel      = (state_q == ST_SRCH) || ((state_q == ST_INV) && inv_ok);
   assign s1_vppn     = (state_q == ST_INV) ? inv_va_q[31:13] : csr_ehi_vppn;
   assign s1_va_bit12 = (state_q == ST_INV) ? inv_va_q[12]    : 1'b0;
   assign s1_asid     = (state_q == ST_INV) ? inv_asid_q      : csr_asid;

   assign we      = (state_q == ST_WR);
   assign w_index = (op_q == OP_FILL) ? fill_q : csr_idx;
   assign w_e     = csr_ecode_tlbr ? 1'b1 : ~csr_ne;
   assign w_vppn  = csr_ehi_vppn;
   assign w_ps    = csr_ps;
   assign w_asid  = csr_asid;
   assign w_g     = g0 & g1;

   assign r_index = csr_idx;

   assign invtlb_valid = (state_q == ST_INV) && inv_ok;
   assign invtlb_op    = inv_op_q;

   assign upd_valid = (state_q == ST_DONE) && ((op_q == OP_SRCH) || (op_q == OP_RD));
   assign upd_kind  = (op_q == OP_RD);
   assign upd_ne    = upd_ne_q;
   assign upd_idx   = upd_idx_q;
   assign upd_ps    = upd_ps_q;
   assign upd_vppn  = upd_vppn_q;
   assign upd_asid  = upd_asid_q;
   assign upd_elo0  = upd_elo0_q;
   assign upd_elo1  = upd_elo1_q;

   assign dbg_state = state_q;

   logic unused_va;
   assign unused_va = ^req.inv_va[11:0];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized bench for tlb_op_ctrl: a behavioural TLB array answers the DUT's ports and a
// spec-level model predicts every pulse, write field and CSR update.
module tb_tlb_op_ctrl;
   import tlb_pkg::*;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0, ppn1;
      logic [1:0]  plv0, plv1, mat0, mat1;
      logic        d0, d1, v0, v1;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   logic [9:0]  csr_asid;
   logic [18:0] csr_ehi_vppn;
   logic [3:0]  csr_idx;
   logic [5:0]  csr_ps;
   logic        csr_ne;
   logic [31:0] csr_elo0, csr_elo1;
   logic        csr_ecode_tlbr;
   logic        s1_sel, s1_va_bit12, s1_found;
   logic [18:0] s1_vppn;
   logic [9:0]  s1_asid;
   logic [3:0]  s1_index;
   logic        we, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
   logic [3:0]  w_index;
   logic [18:0] w_vppn;
   logic [5:0]  w_ps;
   logic [9:0]  w_asid;
   logic [19:0] w_ppn0, w_ppn1;
   logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1;
   logic [3:0]  r_index;
   logic        r_e, r_g, r_d0, r_d1, r_v0, r_v1;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic [19:0] r_ppn0, r_ppn1;
   logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
   logic        invtlb_valid;
   logic [4:0]  invtlb_op;
   logic        upd_valid, upd_kind, upd_ne;
   logic [3:0]  upd_idx;
   logic [5:0]  upd_ps;
   logic [18:0] upd_vppn;
   logic [9:0]  upd_asid;
   logic [31:0] upd_elo0, upd_elo1;
   state_e      dbg_state;

   tlb_op_ctrl_if op_if ();

   tlb_op_ctrl #(.TLBNUM(16)) dut (
      .clk(clk), .reset(reset), .req(op_if.slave),
      .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx), .csr_ps(csr_ps),
      .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_ecode_tlbr(csr_ecode_tlbr),
      .s1_sel(s1_sel), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index),
      .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
      .w_g(w_g), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1),
      .w_mat0(w_mat0), .w_mat1(w_mat1), .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1),
      .r_mat0(r_mat0), .r_mat1(r_mat1), .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
      .upd_valid(upd_valid), .upd_kind(upd_kind), .upd_ne(upd_ne), .upd_idx(upd_idx),
      .upd_ps(upd_ps), .upd_vppn(upd_vppn), .upd_asid(upd_asid),
      .upd_elo0(upd_elo0), .upd_elo1(upd_elo1), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) begin
      if (reset) cyc = 0;
      else cyc = cyc + 1;
   end

   // ---------------- behavioural TLB array ----------------
   ent_t tlb [16] = '{default: '0};

   always @(posedge clk) begin
      if (!reset && we)
         tlb[w_index] <= '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                           ppn0: w_ppn0, ppn1: w_ppn1, plv0: w_plv0, plv1: w_plv1,
                           mat0: w_mat0, mat1: w_mat1, d0: w_d0, d1: w_d1, v0: w_v0, v1: w_v1};
   end

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = 15; i >= 0; i--) begin
         if (tlb[i].e && tlb[i].vppn == s1_vppn && (tlb[i].g || tlb[i].asid == s1_asid)) begin
            s1_found = 1'b1;
            s1_index = 4'(i);
         end
      end
   end

   assign r_e = tlb[r_index].e;       assign r_vppn = tlb[r_index].vppn;
   assign r_ps = tlb[r_index].ps;     assign r_asid = tlb[r_index].asid;
   assign r_g = tlb[r_index].g;       assign r_ppn0 = tlb[r_index].ppn0;
   assign r_ppn1 = tlb[r_index].ppn1; assign r_plv0 = tlb[r_index].plv0;
   assign r_plv1 = tlb[r_index].plv1; assign r_mat0 = tlb[r_index].mat0;
   assign r_mat1 = tlb[r_index].mat1; assign r_d0 = tlb[r_index].d0;
   assign r_d1 = tlb[r_index].d1;     assign r_v0 = tlb[r_index].v0;
   assign r_v1 = tlb[r_index].v1;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   function automatic ent_t write_model(input logic ne, input logic tlbr, input logic [18:0] vppn,
                                        input logic [5:0] ps, input logic [9:0] asid,
                                        input logic [31:0] lo0, input logic [31:0] lo1);
      ent_t x;
      x.e = tlbr ? 1'b1 : !ne;
      x.vppn = vppn; x.ps = ps; x.asid = asid;
      x.g = lo0[6] & lo1[6];
      x.v0 = lo0[0]; x.d0 = lo0[1]; x.plv0 = lo0[3:2]; x.mat0 = lo0[5:4]; x.ppn0 = lo0[27:8];
      x.v1 = lo1[0]; x.d1 = lo1[1]; x.plv1 = lo1[3:2]; x.mat1 = lo1[5:4]; x.ppn1 = lo1[27:8];
      return x;
   endfunction

   function automatic logic [31:0] elo_of(input logic [19:0] ppn, input logic g, input logic [1:0] mat,
                                          input logic [1:0] plv, input logic d, input logic v);
      return (32'(ppn) << 8) | (32'(g) << 6) | (32'(mat) << 4) | (32'(plv) << 2) | (32'(d) << 1) | 32'(v);
   endfunction

   function automatic logic [4:0] search_model(input logic [18:0] vppn, input logic [9:0] asid);
      for (int i = 0; i < 16; i++)
         if (tlb[i].e && tlb[i].vppn == vppn && (tlb[i].g || tlb[i].asid == asid))
            return {1'b1, 4'(i)};
      return 5'd0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic rand_csr();
      csr_asid       = 10'($urandom);
      csr_ehi_vppn   = 19'($urandom);
      csr_idx        = 4'($urandom);
      csr_ps         = ($urandom_range(0, 1) == 0) ? PS_4K : PS_4M;
      csr_ne         = 1'($urandom_range(0, 1));
      csr_elo0       = $urandom;
      csr_elo1       = $urandom;
      csr_ecode_tlbr = ($urandom_range(0, 3) == 0);
      op_if.inv_op   = 5'($urandom_range(0, 10));
      op_if.inv_asid = 10'($urandom);
      op_if.inv_va   = $urandom;
   endtask

   // Issues one op at a negedge with the DUT idle and checks every cycle until idle again.
   task automatic do_op(input logic [2:0] code);
      ent_t       exp_w, rent;
      logic [4:0] srch;
      int         fill_exp;
      logic       inv_ok, exp_s1;
      check_eq("ready_before", 64'(op_if.op_ready), 64'd1);
      op_if.op_valid = 1'b1;
      op_if.op_code  = code;
      fill_exp = cyc % 16;
      exp_w    = write_model(csr_ne, csr_ecode_tlbr, csr_ehi_vppn, csr_ps, csr_asid, csr_elo0, csr_elo1);
      srch     = search_model(csr_ehi_vppn, csr_asid);
      rent     = tlb[csr_idx];
      inv_ok   = (op_if.inv_op <= 5'd6);
      @(negedge clk);
      // Busy-time requests must be ignored.
      op_if.op_valid = 1'($urandom_range(0, 1));
      op_if.op_code  = 3'($urandom);
      if (code > 3'd4) begin
         check_eq("undef_done", 64'(op_if.op_done), 64'd1);
         check_eq("undef_upd", 64'(upd_valid), 64'd0);
         check_eq("undef_we", 64'({we, invtlb_valid, op_if.op_ine, s1_sel}), 64'd0);
      end else begin
         exp_s1 = (code == OP_SRCH) || (code == OP_INV && inv_ok);
         check_eq("op_done_early", 64'(op_if.op_done), 64'd0);
         check_eq("we", 64'(we), 64'(code == OP_WR || code == OP_FILL));
         check_eq("invtlb_valid", 64'(invtlb_valid), 64'(code == OP_INV && inv_ok));
         if (code != OP_INV || inv_ok) check_eq("s1_sel", 64'(s1_sel), 64'(exp_s1));
         if (code == OP_SRCH) begin
            check_eq("srch_key", 64'({s1_vppn, s1_va_bit12, s1_asid}), 64'({csr_ehi_vppn, 1'b0, csr_asid}));
         end
         if (code == OP_WR || code == OP_FILL) begin
            check_eq("w_index", 64'(w_index), (code == OP_FILL) ? 64'(fill_exp) : 64'(csr_idx));
            check_eq("w_e", 64'(w_e), 64'(exp_w.e));
            check_eq("w_g", 64'(w_g), 64'(exp_w.g));
            check_eq("w_hi", 64'({w_vppn, w_ps, w_asid}), 64'({exp_w.vppn, exp_w.ps, exp_w.asid}));
            check_eq("w_lo0", 64'({w_ppn0, w_plv0, w_mat0, w_d0, w_v0}),
                     64'({exp_w.ppn0, exp_w.plv0, exp_w.mat0, exp_w.d0, exp_w.v0}));
            check_eq("w_lo1", 64'({w_ppn1, w_plv1, w_mat1, w_d1, w_v1}),
                     64'({exp_w.ppn1, exp_w.plv1, exp_w.mat1, exp_w.d1, exp_w.v1}));
         end
         if (code == OP_INV && inv_ok) begin
            check_eq("invtlb_op", 64'(invtlb_op), 64'(op_if.inv_op));
            check_eq("inv_key", 64'({s1_vppn, s1_va_bit12, s1_asid}),
                     64'({op_if.inv_va[31:12], op_if.inv_asid}));
         end
         @(negedge clk);
         op_if.op_valid = 1'b0;
         check_eq("op_done", 64'(op_if.op_done), 64'd1);
         check_eq("upd_valid", 64'(upd_valid), 64'(code == OP_SRCH || code == OP_RD));
         check_eq("op_ine", 64'(op_if.op_ine), 64'(code == OP_INV && !inv_ok));
         check_eq("done_quiet", 64'({we, invtlb_valid, s1_sel}), 64'd0);
         if (code == OP_SRCH) begin
            check_eq("srch_kind", 64'(upd_kind), 64'd0);
            check_eq("srch_ne", 64'(upd_ne), 64'(!srch[4]));
            check_eq("srch_idx", 64'(upd_idx), srch[4] ? 64'(srch[3:0]) : 64'(csr_idx));
         end
         if (code == OP_RD) begin
            check_eq("rd_kind", 64'(upd_kind), 64'd1);
            check_eq("rd_ne", 64'(upd_ne), 64'(!rent.e));
            check_eq("rd_hi", 64'({upd_ps, upd_vppn, upd_asid}),
                     rent.e ? 64'({rent.ps, rent.vppn, rent.asid}) : 64'd0);
            check_eq("rd_elo0", 64'(upd_elo0),
                     rent.e ? 64'(elo_of(rent.ppn0, rent.g, rent.mat0, rent.plv0, rent.d0, rent.v0)) : 64'd0);
            check_eq("rd_elo1", 64'(upd_elo1),
                     rent.e ? 64'(elo_of(rent.ppn1, rent.g, rent.mat1, rent.plv1, rent.d1, rent.v1)) : 64'd0);
         end
      end
      @(negedge clk);
      op_if.op_valid = 1'b0;
      check_eq("ready_after", 64'(op_if.op_ready), 64'd1);
      check_eq("done_after", 64'(op_if.op_done), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] saved_lo0, saved_lo1;
   logic [2:0]  rcode;
   int          j;

   initial begin
      op_if.op_valid = 1'b0;
      op_if.op_code  = '0;
      reset = 1'b1;
      rand_csr();
      repeat (2) @(negedge clk);
      check_eq("rst_ready", 64'(op_if.op_ready), 64'd1);
      check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      check_eq("rst_pulses", 64'({we, invtlb_valid, upd_valid, op_if.op_done, op_if.op_ine, s1_sel}), 64'd0);
      check_eq("rst_upd", 64'({upd_ne, upd_idx, upd_ps, upd_vppn, upd_asid}), 64'd0);
      check_eq("rst_elo", 64'({upd_elo0, upd_elo1}), 64'd0);
      reset = 1'b0;

      // RD of never-written entry 9
      csr_idx = 4'd9;
      do_op(OP_RD);

      // WR idx 5, NE=1, not in TLBR: entry invalid; only one G set
      csr_idx = 4'd5; csr_ne = 1'b1; csr_ecode_tlbr = 1'b0; csr_ehi_vppn = 19'h00aaa;
      csr_elo0 = csr_elo0 | 32'h40; csr_elo1 = csr_elo1 & ~32'h40;
      do_op(OP_WR);
      csr_ecode_tlbr = 1'b1; csr_elo1 = csr_elo1 | 32'h40;
      do_op(OP_WR);

      // Entry 7 with non-global mapping, then hit on it
      csr_idx = 4'd7; csr_ne = 1'b0; csr_ecode_tlbr = 1'b0;
      csr_ehi_vppn = 19'h12345; csr_asid = 10'd3; csr_elo1 = csr_elo1 & ~32'h40;
      do_op(OP_WR);
      csr_idx = 4'd2;
      do_op(OP_SRCH);
      csr_ehi_vppn = 19'h7ffff; csr_asid = 10'd1; csr_idx = 4'd11;
      do_op(OP_SRCH);

      // WR then RD of entry 4 must round-trip the ELO values exactly
      csr_idx = 4'd4; csr_ne = 1'b0;
      saved_lo0 = elo_of(20'($urandom), 1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      saved_lo1 = elo_of(20'($urandom), 1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      csr_elo0 = saved_lo0; csr_elo1 = saved_lo1;
      do_op(OP_WR);
      rand_csr();
      csr_idx = 4'd4;
      do_op(OP_RD);
      check_eq("rt_elo0", 64'(upd_elo0), 64'(saved_lo0));
      check_eq("rt_elo1", 64'(upd_elo1), 64'(saved_lo1));

      // INVTLB valid and illegal op
      op_if.inv_op = 5'd5;
      do_op(OP_INV);
      op_if.inv_op = 5'd9;
      do_op(OP_INV);

      // Undefined op code
      do_op(3'd6);

      // Reset in the middle of a search
      op_if.op_valid = 1'b1; op_if.op_code = OP_SRCH;
      @(negedge clk);
      op_if.op_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      check_eq("abort_done", 64'({op_if.op_done, upd_valid, s1_sel}), 64'd0);
      check_eq("abort_ready", 64'(op_if.op_ready), 64'd1);
      check_eq("abort_upd", 64'({upd_ne, upd_idx}), 64'd0);
      reset = 1'b0;

      // FILL accepted 19 cycles after reset
      for (int k = 0; k < 40 && cyc < 19; k++) @(negedge clk);
      check_eq("fill_cycle", 64'(cyc), 64'd19);
      do_op(OP_FILL);

      // Randomized mix
      for (int n = 0; n < 150; n++) begin
         rand_csr();
         rcode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         if (rcode == OP_SRCH && $urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, 15);
            csr_ehi_vppn = tlb[j].vppn;
            csr_asid     = tlb[j].asid;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_op(rcode);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
